// File: rtl/history_buffer_mp_if.sv
// History buffer bus bundle: decode allocation, writeback/completion ports,
// retire, kill, rollback and exception report signals.
// master : producer side (decode / execute / test driver)
// slave  : the history buffer itself
// Clock and reset are not part of the bundle; they stay plain module ports.
interface history_buffer_mp_if #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int WB_PORTS = 2
);
  logic                      flush_i;
  logic                      alloc_val_i;
  logic                      alloc_rdy_o;
  logic [TAG_W-1:0]          alloc_tag_o;
  logic [XLEN-1:0]           alloc_pc_i;
  logic                      alloc_we_i;
  logic [REG_W-1:0]          alloc_reg_i;
  logic [XLEN-1:0]           alloc_old_val_i;
  logic [WB_PORTS-1:0]       wb_val_i;
  logic [WB_PORTS*TAG_W-1:0] wb_tag_i;
  logic [WB_PORTS*XLEN-1:0]  wb_exc_i;
  logic [WB_PORTS*XLEN-1:0]  wb_mtval_i;
  logic                      commit_val_o;
  logic [XLEN-1:0]           commit_pc_o;
  logic [TAG_W:0]            count_o;
  logic                      stall_o;
  logic                      kill_o;
  logic [XLEN-1:0]           kill_pc_o;
  logic                      rec_we_o;
  logic [REG_W-1:0]          rec_reg_o;
  logic [XLEN-1:0]           rec_val_o;
  logic                      exc_val_o;
  logic [XLEN-1:0]           exc_mepc_o;
  logic [XLEN-1:0]           exc_mcause_o;
  logic [XLEN-1:0]           exc_mtval_o;

  modport master (
    output flush_i, alloc_val_i, alloc_pc_i, alloc_we_i, alloc_reg_i, alloc_old_val_i,
           wb_val_i, wb_tag_i, wb_exc_i, wb_mtval_i,
    input  alloc_rdy_o, alloc_tag_o, commit_val_o, commit_pc_o, count_o, stall_o,
           kill_o, kill_pc_o, rec_we_o, rec_reg_o, rec_val_o,
           exc_val_o, exc_mepc_o, exc_mcause_o, exc_mtval_o
  );

  modport slave (
    input  flush_i, alloc_val_i, alloc_pc_i, alloc_we_i, alloc_reg_i, alloc_old_val_i,
           wb_val_i, wb_tag_i, wb_exc_i, wb_mtval_i,
    output alloc_rdy_o, alloc_tag_o, commit_val_o, commit_pc_o, count_o, stall_o,
           kill_o, kill_pc_o, rec_we_o, rec_reg_o, rec_val_o,
           exc_val_o, exc_mepc_o, exc_mcause_o, exc_mtval_o
  );
endinterface

// File: rtl/history_buffer_mp.sv
// Tag-indexed history buffer for precise exceptions in an in-order pipeline.
// Decode allocates one entry per instruction (PC + pre-write destination
// value); any writeback port marks an entry done with cause/mtval. Entries
// retire in order at the head. An excepting head raises kill, then rolls the
// register file back youngest-to-oldest, then reports the exception.
// Ports:
//   clk_i : clock, rising edge
//   rsn_i : synchronous active-high reset
//   bus   : history_buffer_mp_if.slave (allocation, writeback, retire,
//           kill, rollback, exception report, occupancy, stall)
//
// state   | meaning
// IDLE    | allocate, accept writebacks, retire or detect an excepting head
// RECOVER | one rollback step per cycle from youngest entry down to head
module history_buffer_mp #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int WB_PORTS = 2
) (
  input logic               clk_i,
  input logic               rsn_i,
  history_buffer_mp_if.slave bus
);

  typedef enum logic {IDLE, RECOVER} state_t;

  localparam logic [TAG_W:0]   FULL  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   ONE_C = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] ONE_T = TAG_W'(1);

  state_t state, state_nxt;

  logic [DEPTH-1:0] valid, done, we_q;
  logic [REG_W-1:0] reg_q     [DEPTH];
  logic [XLEN-1:0]  old_val_q [DEPTH];
  logic [XLEN-1:0]  pc_q      [DEPTH];
  logic [XLEN-1:0]  exc_q     [DEPTH];
  logic [XLEN-1:0]  mtval_q   [DEPTH];

  logic [TAG_W-1:0] head, tail, tail_nxt, rec_idx;
  logic [TAG_W:0]   count;

  logic                active, alloc_acc, head_ready, retire, kill, rec_last;
  logic [WB_PORTS-1:0] wb_ok;
  logic [TAG_W-1:0]    wb_tag [WB_PORTS];

  logic             commit_val, kill_v, rec_we, exc_v;
  logic [XLEN-1:0]  commit_pc, kill_pc, rec_val, mepc, mcause, mtval;
  logic [REG_W-1:0] rec_reg;

  always_comb begin
    active     = !rsn_i && !bus.flush_i;
    alloc_acc  = bus.alloc_val_i && (state == IDLE) && (count < FULL) && active;
    head_ready = valid[head] && done[head];
    retire     = 1'b0;
    kill       = 1'b0;
    rec_last   = 1'b0;
    state_nxt  = state;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_tag[p] = bus.wb_tag_i[p*TAG_W +: TAG_W];
      // Only a live, not-yet-finished entry accepts a completion.
      wb_ok[p]  = active && (state == IDLE) && bus.wb_val_i[p] &&
                  valid[wb_tag[p]] && !done[wb_tag[p]];
    end
    case (state)
      IDLE: begin
        if (active && head_ready) begin
          if (exc_q[head] == '0) begin
            retire = 1'b1;
          end else begin
            kill      = 1'b1;
            state_nxt = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (active && (rec_idx == head)) begin
          rec_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    tail_nxt = alloc_acc ? tail + ONE_T : tail;
  end

  assign bus.alloc_rdy_o  = alloc_acc;
  assign bus.alloc_tag_o  = tail;
  assign bus.count_o      = count;
  assign bus.stall_o      = (state == RECOVER) && !rsn_i;
  assign bus.commit_val_o = commit_val;
  assign bus.commit_pc_o  = commit_pc;
  assign bus.kill_o       = kill_v;
  assign bus.kill_pc_o    = kill_pc;
  assign bus.rec_we_o     = rec_we;
  assign bus.rec_reg_o    = rec_reg;
  assign bus.rec_val_o    = rec_val;
  assign bus.exc_val_o    = exc_v;
  assign bus.exc_mepc_o   = mepc;
  assign bus.exc_mcause_o = mcause;
  assign bus.exc_mtval_o  = mtval;

  // Control: state, pointers, valid/done bits and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state      <= IDLE;
      valid      <= '0;
      done       <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rec_idx    <= '0;
      commit_val <= 1'b0;
      commit_pc  <= '0;
      kill_v     <= 1'b0;
      kill_pc    <= '0;
      rec_we     <= 1'b0;
      rec_reg    <= '0;
      rec_val    <= '0;
      exc_v      <= 1'b0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else begin
      commit_val <= 1'b0;
      kill_v     <= 1'b0;
      rec_we     <= 1'b0;
      exc_v      <= 1'b0;
      if (bus.flush_i) begin
        state <= IDLE;
        valid <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        state <= state_nxt;
        if (alloc_acc) begin
          valid[tail] <= 1'b1;
          done[tail]  <= 1'b0;
        end
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_ok[p]) done[wb_tag[p]] <= 1'b1;
        end
        if (retire) begin
          valid[head] <= 1'b0;
          done[head]  <= 1'b0;
          head        <= head + ONE_T;
          commit_val  <= 1'b1;
          commit_pc   <= pc_q[head];
        end
        if (kill) begin
          kill_v  <= 1'b1;
          kill_pc <= pc_q[head];
          // Start the rollback at the youngest entry, including one
          // allocated on this same edge.
          rec_idx <= tail_nxt - ONE_T;
        end
        tail  <= tail_nxt;
        count <= count + (alloc_acc ? ONE_C : '0) - (retire ? ONE_C : '0);
        if (state == RECOVER) begin
          rec_we  <= we_q[rec_idx];
          rec_reg <= reg_q[rec_idx];
          rec_val <= old_val_q[rec_idx];
          if (rec_last) begin
            exc_v  <= 1'b1;
            mepc   <= pc_q[head];
            mcause <= exc_q[head];
            mtval  <= mtval_q[head];
            valid  <= '0;
            done   <= '0;
            tail   <= head;
            count  <= '0;
          end else begin
            rec_idx <= rec_idx - ONE_T;
          end
        end
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  // Later ports are written last, so the highest port index wins a tag clash.
  always_ff @(posedge clk_i) begin
    if (alloc_acc) begin
      we_q[tail]      <= bus.alloc_we_i;
      reg_q[tail]     <= bus.alloc_reg_i;
      old_val_q[tail] <= bus.alloc_old_val_i;
      pc_q[tail]      <= bus.alloc_pc_i;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_ok[p]) begin
        exc_q[wb_tag[p]]   <= bus.wb_exc_i[p*XLEN +: XLEN];
        mtval_q[wb_tag[p]] <= bus.wb_mtval_i[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_history_buffer_mp.sv
module tb_history_buffer_mp;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int WBP   = 2;

  logic clk;
  logic rsn;
  int   n_cmp = 0;
  int   n_err = 0;

  history_buffer_mp_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .REG_W(REG_W),
                         .WB_PORTS(WBP)) bus ();

  history_buffer_mp #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .REG_W(REG_W),
                      .WB_PORTS(WBP)) dut (
    .clk_i(clk),
    .rsn_i(rsn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic we, input logic [4:0] rg,
                          input logic [31:0] old, input logic [1:0] exp_tag);
    bus.alloc_val_i     = 1'b1;
    bus.alloc_pc_i      = pc;
    bus.alloc_we_i      = we;
    bus.alloc_reg_i     = rg;
    bus.alloc_old_val_i = old;
    #1;
    chk("alloc_rdy", 32'(bus.alloc_rdy_o), 1);
    chk("alloc_tag", 32'(bus.alloc_tag_o), 32'(exp_tag));
    tick();
    bus.alloc_val_i = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [1:0] tag, input logic [31:0] exc,
                        input logic [31:0] mtv);
    bus.wb_val_i[p]             = 1'b1;
    bus.wb_tag_i[p*TAG_W +: TAG_W] = tag;
    bus.wb_exc_i[p*XLEN +: XLEN]   = exc;
    bus.wb_mtval_i[p*XLEN +: XLEN] = mtv;
  endtask

  task automatic do_reset();
    rsn = 1'b1;
    tick();
    rsn = 1'b0;
  endtask

  initial begin
    rsn                 = 1'b1;
    bus.flush_i         = 1'b0;
    bus.alloc_val_i     = 1'b1;
    bus.alloc_pc_i      = '0;
    bus.alloc_we_i      = 1'b0;
    bus.alloc_reg_i     = '0;
    bus.alloc_old_val_i = '0;
    bus.wb_val_i        = '0;
    bus.wb_tag_i        = '0;
    bus.wb_exc_i        = '0;
    bus.wb_mtval_i      = '0;
    tick();
    tick();
    // Reset state
    chk("rst_alloc_rdy", 32'(bus.alloc_rdy_o), 0);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_commit", 32'(bus.commit_val_o), 0);
    chk("rst_kill", 32'(bus.kill_o), 0);
    chk("rst_rec_we", 32'(bus.rec_we_o), 0);
    chk("rst_exc", 32'(bus.exc_val_o), 0);
    bus.alloc_val_i = 1'b0;
    rsn = 1'b0;

    // In-order retire with out-of-order completion
    do_alloc(32'h100, 1'b1, 5'd1, 32'h1, 2'd0);
    do_alloc(32'h104, 1'b1, 5'd2, 32'h2, 2'd1);
    do_alloc(32'h108, 1'b1, 5'd3, 32'h3, 2'd2);
    chk("t1_count3", 32'(bus.count_o), 3);
    set_wb(0, 2'd2, 0, 0);
    tick();
    chk("t1_no_commit_a", 32'(bus.commit_val_o), 0);
    set_wb(0, 2'd0, 0, 0);
    tick();
    chk("t1_no_commit_b", 32'(bus.commit_val_o), 0);
    set_wb(0, 2'd1, 0, 0);
    tick();
    bus.wb_val_i = '0;
    chk("t1_commit0", 32'(bus.commit_val_o), 1);
    chk("t1_pc0", bus.commit_pc_o, 32'h100);
    tick();
    chk("t1_commit1", 32'(bus.commit_val_o), 1);
    chk("t1_pc1", bus.commit_pc_o, 32'h104);
    tick();
    chk("t1_commit2", 32'(bus.commit_val_o), 1);
    chk("t1_pc2", bus.commit_pc_o, 32'h108);
    chk("t1_count0", 32'(bus.count_o), 0);
    tick();
    chk("t1_commit_idle", 32'(bus.commit_val_o), 0);

    // Full buffer and tail wrap
    do_reset();
    do_alloc(32'h200, 1'b1, 5'd1, 32'h0, 2'd0);
    do_alloc(32'h204, 1'b1, 5'd2, 32'h0, 2'd1);
    do_alloc(32'h208, 1'b1, 5'd3, 32'h0, 2'd2);
    do_alloc(32'h20C, 1'b1, 5'd4, 32'h0, 2'd3);
    bus.alloc_val_i = 1'b1;
    #1;
    chk("t2_full_rdy", 32'(bus.alloc_rdy_o), 0);
    chk("t2_count4", 32'(bus.count_o), 4);
    tick();
    bus.alloc_val_i = 1'b0;
    chk("t2_count_hold", 32'(bus.count_o), 4);
    set_wb(0, 2'd0, 0, 0);
    tick();
    bus.wb_val_i = '0;
    chk("t2_no_commit", 32'(bus.commit_val_o), 0);
    bus.alloc_val_i = 1'b1;
    #1;
    chk("t2_rdy_during_retire", 32'(bus.alloc_rdy_o), 0);
    tick();
    bus.alloc_val_i = 1'b0;
    chk("t2_commit", 32'(bus.commit_val_o), 1);
    chk("t2_commit_pc", bus.commit_pc_o, 32'h200);
    chk("t2_count3", 32'(bus.count_o), 3);
    do_alloc(32'h210, 1'b1, 5'd5, 32'h0, 2'd0);
    chk("t2_count_refill", 32'(bus.count_o), 4);

    // Two ports in one cycle, then a same-tag clash (higher port wins)
    set_wb(0, 2'd2, 0, 0);
    set_wb(1, 2'd1, 0, 0);
    tick();
    bus.wb_val_i = '0;
    chk("t3_no_commit", 32'(bus.commit_val_o), 0);
    tick();
    chk("t3_commit_a", 32'(bus.commit_val_o), 1);
    chk("t3_pc_a", bus.commit_pc_o, 32'h204);
    tick();
    chk("t3_commit_b", 32'(bus.commit_val_o), 1);
    chk("t3_pc_b", bus.commit_pc_o, 32'h208);
    chk("t3_count2", 32'(bus.count_o), 2);
    set_wb(0, 2'd3, 5, 32'h77);
    set_wb(1, 2'd3, 0, 0);
    tick();
    bus.wb_val_i = '0;
    tick();
    chk("t3_clash_commit", 32'(bus.commit_val_o), 1);
    chk("t3_clash_pc", bus.commit_pc_o, 32'h20C);
    chk("t3_clash_kill", 32'(bus.kill_o), 0);
    set_wb(0, 2'd0, 0, 0);
    tick();
    bus.wb_val_i = '0;
    tick();
    chk("t3_commit_wrap", 32'(bus.commit_val_o), 1);
    chk("t3_pc_wrap", bus.commit_pc_o, 32'h210);
    chk("t3_count0", 32'(bus.count_o), 0);

    // Exception at head: kill, rollback x4,x3,x2(no write),x1, report
    do_reset();
    do_alloc(32'h300, 1'b1, 5'd1, 32'hA, 2'd0);
    do_alloc(32'h304, 1'b0, 5'd2, 32'hB, 2'd1);
    do_alloc(32'h308, 1'b1, 5'd3, 32'hC, 2'd2);
    do_alloc(32'h30C, 1'b1, 5'd4, 32'hD, 2'd3);
    set_wb(1, 2'd0, 2, 32'hBEEF);
    tick();
    bus.wb_val_i = '0;
    chk("t4_kill_early", 32'(bus.kill_o), 0);
    tick();
    chk("t4_kill", 32'(bus.kill_o), 1);
    chk("t4_kill_pc", bus.kill_pc_o, 32'h300);
    chk("t4_stall_kill", 32'(bus.stall_o), 1);
    chk("t4_rec_none", 32'(bus.rec_we_o), 0);
    tick();
    chk("t4_kill_pulse", 32'(bus.kill_o), 0);
    chk("t4_r1_we", 32'(bus.rec_we_o), 1);
    chk("t4_r1_reg", 32'(bus.rec_reg_o), 4);
    chk("t4_r1_val", bus.rec_val_o, 32'hD);
    chk("t4_r1_stall", 32'(bus.stall_o), 1);
    tick();
    chk("t4_r2_we", 32'(bus.rec_we_o), 1);
    chk("t4_r2_reg", 32'(bus.rec_reg_o), 3);
    chk("t4_r2_val", bus.rec_val_o, 32'hC);
    tick();
    chk("t4_r3_we", 32'(bus.rec_we_o), 0);
    chk("t4_r3_reg", 32'(bus.rec_reg_o), 2);
    chk("t4_r3_stall", 32'(bus.stall_o), 1);
    chk("t4_r3_exc", 32'(bus.exc_val_o), 0);
    tick();
    chk("t4_r4_we", 32'(bus.rec_we_o), 1);
    chk("t4_r4_reg", 32'(bus.rec_reg_o), 1);
    chk("t4_r4_val", bus.rec_val_o, 32'hA);
    chk("t4_exc", 32'(bus.exc_val_o), 1);
    chk("t4_mepc", bus.exc_mepc_o, 32'h300);
    chk("t4_mcause", bus.exc_mcause_o, 2);
    chk("t4_mtval", bus.exc_mtval_o, 32'hBEEF);
    chk("t4_stall_exc", 32'(bus.stall_o), 0);
    chk("t4_count0", 32'(bus.count_o), 0);
    tick();
    chk("t4_exc_pulse", 32'(bus.exc_val_o), 0);
    chk("t4_rec_done", 32'(bus.rec_we_o), 0);

    // Reset in the middle of a rollback
    do_alloc(32'h400, 1'b1, 5'd5, 32'h1, 2'd0);
    do_alloc(32'h404, 1'b1, 5'd6, 32'h2, 2'd1);
    do_alloc(32'h408, 1'b1, 5'd7, 32'h3, 2'd2);
    set_wb(0, 2'd0, 1, 32'h55);
    tick();
    bus.wb_val_i = '0;
    tick();
    chk("t5_kill", 32'(bus.kill_o), 1);
    tick();
    chk("t5_r1_reg", 32'(bus.rec_reg_o), 7);
    chk("t5_r1_val", bus.rec_val_o, 32'h3);
    tick();
    chk("t5_r2_we", 32'(bus.rec_we_o), 1);
    chk("t5_r2_reg", 32'(bus.rec_reg_o), 6);
    rsn = 1'b1;
    #1;
    chk("t5_stall_in_rst", 32'(bus.stall_o), 0);
    tick();
    chk("t5_rst_rec_we", 32'(bus.rec_we_o), 0);
    chk("t5_rst_rec_reg", 32'(bus.rec_reg_o), 0);
    chk("t5_rst_rec_val", bus.rec_val_o, 0);
    chk("t5_rst_exc", 32'(bus.exc_val_o), 0);
    chk("t5_rst_kill_pc", bus.kill_pc_o, 0);
    chk("t5_rst_count", 32'(bus.count_o), 0);
    rsn = 1'b0;
    tick();
    chk("t5_after_rec_we", 32'(bus.rec_we_o), 0);
    chk("t5_after_exc", 32'(bus.exc_val_o), 0);
    chk("t5_after_stall", 32'(bus.stall_o), 0);
    do_alloc(32'h500, 1'b1, 5'd8, 32'h0, 2'd0);

    // Flush with entries pending, stale writeback afterwards
    do_alloc(32'h504, 1'b1, 5'd9, 32'h0, 2'd1);
    do_alloc(32'h508, 1'b1, 5'd10, 32'h0, 2'd2);
    chk("t6_count3", 32'(bus.count_o), 3);
    bus.flush_i     = 1'b1;
    bus.alloc_val_i = 1'b1;
    #1;
    chk("t6_flush_rdy", 32'(bus.alloc_rdy_o), 0);
    tick();
    bus.flush_i     = 1'b0;
    bus.alloc_val_i = 1'b0;
    chk("t6_count0", 32'(bus.count_o), 0);
    chk("t6_kill", 32'(bus.kill_o), 0);
    chk("t6_rec", 32'(bus.rec_we_o), 0);
    chk("t6_exc", 32'(bus.exc_val_o), 0);
    set_wb(0, 2'd0, 0, 0);
    tick();
    bus.wb_val_i = '0;
    tick();
    chk("t6_stale_commit", 32'(bus.commit_val_o), 0);
    chk("t6_stale_count", 32'(bus.count_o), 0);
    tick();
    chk("t6_stale_commit2", 32'(bus.commit_val_o), 0);
    do_alloc(32'h600, 1'b1, 5'd11, 32'h0, 2'd0);
    chk("t6_count1", 32'(bus.count_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
